// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback write arbiter.
//               Holds the queued write request layout, the arbiter FSM state
//               encoding and a one-hot helper used to build the pending map.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  // Architectural register count; the pending bitmap is always this wide.
  localparam int REG_COUNT = 32;

  // Request field widths. The arbiter's DATA_W/ADDR_W parameters must match.
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] wd;
  } wb_req_t;

  typedef enum logic [0:0] {
    LOAD_PRI = 1'b0,
    DRAIN    = 1'b1
  } wb_state_e;

  function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [WB_ADDR_W-1:0] rd);
    logic [REG_COUNT-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter_if
// Description : Bus bundle for the writeback write arbiter: ALU result and
//               load response handshakes, the register-file write port, the
//               pending-write bitmap and the ALU buffer occupancy.
// Ports       : none; signals grouped by modport
//   master : producer / observer side (drives valid+rd+wd, sees ready and
//            the register-file port)
//   slave  : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_arbiter_if
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                 alu_valid;
  logic                 alu_ready;
  logic [ADDR_W-1:0]    alu_rd;
  logic [DATA_W-1:0]    alu_wd;

  logic                 ld_valid;
  logic                 ld_ready;
  logic [ADDR_W-1:0]    ld_rd;
  logic [DATA_W-1:0]    ld_wd;

  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_rd;
  logic [DATA_W-1:0]    rf_wd;

  logic [REG_COUNT-1:0] pending;
  logic [CNT_W-1:0]     fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_wd,
    output ld_valid, ld_rd, ld_wd,
    input  alu_ready, ld_ready,
    input  rf_we, rf_rd, rf_wd,
    input  pending, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  ld_valid, ld_rd, ld_wd,
    output alu_ready, ld_ready,
    output rf_we, rf_rd, rf_wd,
    output pending, fifo_count
  );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of wb_req_t. Besides the usual head/push/pop
//               it exposes every storage slot plus a per-slot valid mask so
//               the owner can derive a bitmap of queued destinations.
// Ports       :
//   clk, rst         clock, synchronous active-high reset
//   i_push, i_data   enqueue request (ignored while full)
//   i_pop            dequeue request (ignored while empty)
//   o_head           oldest entry
//   o_full, o_empty  status
//   o_count          occupied entries
//   o_entries        raw storage slots
//   o_valid          slot i holds a live entry
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_push,
  input  wire wb_req_t              i_data,
  input  wire logic                 i_pop,
  output wb_req_t                   o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [CNT_W-1:0]          o_count,
  output wb_req_t [DEPTH-1:0]       o_entries,
  output logic [DEPTH-1:0]          o_valid
);

  wb_req_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage needs no reset: o_valid gates every slot.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_entries = r_mem;

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PTR_W-1:0] w_off;
    assign w_off      = PTR_W'(i) - r_rd_ptr;
    assign o_valid[i] = (CNT_W'(w_off) < r_count);
  end

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Writeback-side producer for the register-file write port.
//               Buffers ALU results in a FIFO, arbitrates them against load
//               responses and drives a registered we/rd/wd port. Loads win in
//               LOAD_PRI; once the buffer fills, DRAIN blocks loads until the
//               buffer is nearly empty again. Publishes a pending-write map.
// Ports       :
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   wb_write_arbiter_if.slave:
//           alu_valid/alu_ready/alu_rd/alu_wd   ALU result handshake
//           ld_valid/ld_ready/ld_rd/ld_wd       load response handshake
//           rf_we/rf_rd/rf_wd                   registered write port
//           pending                             queued/in-flight writes
//           fifo_count                          ALU buffer occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wb_write_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_state_e r_state;
  wb_state_e w_state_nxt;

  logic                 r_we;
  logic [ADDR_W-1:0]    r_rd;
  logic [DATA_W-1:0]    r_wd;

  wb_req_t                  w_alu_req;
  wb_req_t                  w_head;
  wb_req_t [FIFO_DEPTH-1:0] w_entries;
  logic [FIFO_DEPTH-1:0]    w_valid;
  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W-1:0]         w_count;

  logic                 w_alu_ready;
  logic                 w_ld_ready;
  logic                 w_alu_live;
  logic                 w_ld_live;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_flow;
  logic                 w_sel_valid;
  logic [ADDR_W-1:0]    w_sel_rd;
  logic [DATA_W-1:0]    w_sel_wd;
  int                   w_cnt_nxt;
  logic [REG_COUNT-1:0] w_pending;

  // Readies are forced low during reset so nothing is consumed then.
  assign w_alu_ready = !rst && !w_full;
  assign w_ld_ready  = !rst && (r_state == LOAD_PRI);

  // A "live" transfer is an accepted one that targets a real register;
  // accepted x0 transfers are simply swallowed.
  assign w_alu_live = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
  assign w_ld_live  = bus.ld_valid  && w_ld_ready  && (bus.ld_rd  != '0);

  assign w_alu_req.rd = bus.alu_rd;
  assign w_alu_req.wd = bus.alu_wd;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_alu_req),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD_PRI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Source selection and next state. The transition tests use the
  // occupancy after this cycle's push/pop.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_valid = 1'b0;
    w_sel_rd    = '0;
    w_sel_wd    = '0;
    w_pop       = 1'b0;
    w_flow      = 1'b0;
    w_push      = 1'b0;
    w_cnt_nxt   = 0;

    case (r_state)
      LOAD_PRI: begin
        if (w_ld_live) begin
          w_sel_valid = 1'b1;
          w_sel_rd    = bus.ld_rd;
          w_sel_wd    = bus.ld_wd;
        end else if (!w_empty) begin
          w_sel_valid = 1'b1;
          w_pop       = 1'b1;
          w_sel_rd    = w_head.rd;
          w_sel_wd    = w_head.wd;
        end else if (w_alu_live) begin
          // Empty buffer and idle load side: bypass the FIFO entirely.
          w_sel_valid = 1'b1;
          w_flow      = 1'b1;
          w_sel_rd    = bus.alu_rd;
          w_sel_wd    = bus.alu_wd;
        end
      end
      DRAIN: begin
        if (!w_empty) begin
          w_sel_valid = 1'b1;
          w_pop       = 1'b1;
          w_sel_rd    = w_head.rd;
          w_sel_wd    = w_head.wd;
        end
      end
      default: begin
        w_state_nxt = LOAD_PRI;
      end
    endcase

    w_push    = w_alu_live && !w_flow;
    w_cnt_nxt = int'(w_count) + int'(w_push) - int'(w_pop);

    if (r_state == LOAD_PRI && w_cnt_nxt == FIFO_DEPTH) begin
      w_state_nxt = DRAIN;
    end else if (r_state == DRAIN && w_cnt_nxt <= 1) begin
      w_state_nxt = LOAD_PRI;
    end
  end

  // The register file samples on the falling edge, so the port is
  // registered here on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_sel_valid;
      if (w_sel_valid) begin
        r_rd <= w_sel_rd;
        r_wd <= w_sel_wd;
      end
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_valid[i]) begin
        w_pending = w_pending | rd_onehot(w_entries[i].rd);
      end
    end
    if (r_we) begin
      w_pending = w_pending | rd_onehot(r_rd);
    end
    w_pending[0] = 1'b0;
  end

  assign bus.alu_ready  = w_alu_ready;
  assign bus.ld_ready   = w_ld_ready;
  assign bus.rf_we      = r_we;
  assign bus.rf_rd      = r_rd;
  assign bus.rf_wd      = r_wd;
  assign bus.pending    = w_pending;
  assign bus.fifo_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_arbiter
// Description : Self-checking bench for wb_write_arbiter. A queue-based
//               reference model predicts readies, the write port, occupancy
//               and the pending map; directed scenarios are followed by a
//               randomized run with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } tb_req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) bus ();

  wb_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: ALU buffer contents, drain mode, expected port.
  tb_req_t     q[$];
  bit          m_drain;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (q[i]) p[q[i].rd] = 1'b1;
    if (m_we) p[m_rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic check_port(input string pfx);
    chk({pfx, "_we"}, 64'(bus.rf_we), 64'(m_we));
    if (m_we) begin
      chk({pfx, "_rd"}, 64'(bus.rf_rd), 64'(m_rd));
      chk({pfx, "_wd"}, 64'(bus.rf_wd), 64'(m_wd));
    end
    chk({pfx, "_count"}, 64'(bus.fifo_count), 64'(q.size()));
    chk({pfx, "_pending"}, 64'(bus.pending), 64'(model_pending()));
  endtask

  // One cycle: drive inputs, check readies, advance model, check the port.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] awd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] lwd);
    bit a_rdy, l_rdy, a_acc, l_acc, taken;
    tb_req_t e;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_wd = awd;
    bus.ld_valid  = lv; bus.ld_rd  = lrd; bus.ld_wd  = lwd;
    #1;
    a_rdy = (q.size() < DEPTH);
    l_rdy = !m_drain;
    chk("alu_ready", 64'(bus.alu_ready), 64'(a_rdy));
    chk("ld_ready",  64'(bus.ld_ready),  64'(l_rdy));
    a_acc = av && a_rdy;
    l_acc = lv && l_rdy;
    taken = 1'b0;
    m_we  = 1'b0;
    if (m_drain) begin
      e = q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_wd = e.wd;
    end else if (l_acc && lrd != 0) begin
      m_we = 1'b1; m_rd = lrd; m_wd = lwd;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_wd = e.wd;
    end else if (a_acc && ard != 0) begin
      m_we = 1'b1; m_rd = ard; m_wd = awd; taken = 1'b1;
    end
    if (a_acc && ard != 0 && !taken) q.push_back('{rd: ard, wd: awd});
    if (!m_drain && q.size() == DEPTH) m_drain = 1'b1;
    else if (m_drain && q.size() <= 1) m_drain = 1'b0;
    @(posedge clk); #1;
    check_port("port");
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_wd = 32'h55;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd8; bus.ld_wd  = 32'h66;
    #1;
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst_ld_ready",  64'(bus.ld_ready),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    q.delete(); m_drain = 1'b0; m_we = 1'b0; m_rd = '0; m_wd = '0;
    chk("rst_we",      64'(bus.rf_we),      64'd0);
    chk("rst_rd",      64'(bus.rf_rd),      64'd0);
    chk("rst_wd",      64'(bus.rf_wd),      64'd0);
    chk("rst_count",   64'(bus.fifo_count), 64'd0);
    chk("rst_pending", 64'(bus.pending),    64'd0);
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_wd = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_wd  = '0;
    q.delete(); m_drain = 1'b0; m_we = 1'b0; m_rd = '0; m_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single ALU result flows straight through.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    chk("t1_rd", 64'(bus.rf_rd), 64'd5);
    chk("t1_wd", 64'(bus.rf_wd), 64'hDEAD_BEEF);
    chk("t1_p5", 64'(bus.pending[5]), 64'd1);
    idle();
    chk("t1_p5_clr", 64'(bus.pending[5]), 64'd0);

    // Load beats a simultaneous ALU result.
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
    chk("t2_rd_ld", 64'(bus.rf_rd), 64'd7);
    chk("t2_cnt1", 64'(bus.fifo_count), 64'd1);
    idle();
    chk("t2_rd_alu", 64'(bus.rf_rd), 64'd3);
    chk("t2_cnt0", 64'(bus.fifo_count), 64'd0);

    // Loads every cycle while four ALU results pile up, then DRAIN.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'(i), 32'(100 + i), 1'b1, 5'(10 + i), 32'(200 + i));
    chk("t3_cnt4", 64'(bus.fifo_count), 64'd4);
    chk("t3_ld_blocked", 64'(bus.ld_ready), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hCC);
      chk("t3_drain_rd", 64'(bus.rf_rd), 64'(i));
    end
    chk("t3_ld_back", 64'(bus.ld_ready), 64'd1);
    repeat (3) idle();

    // x0 transfers are accepted and dropped.
    step(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h1234);
    chk("t4_we", 64'(bus.rf_we), 64'd0);
    chk("t4_pending", 64'(bus.pending), 64'd0);
    chk("t4_cnt", 64'(bus.fifo_count), 64'd0);

    // Two queued writes to x9 keep pending[9] up until the last retires.
    step(1'b1, 5'd9,  32'h91, 1'b1, 5'd20, 32'h1);
    step(1'b1, 5'd11, 32'hB1, 1'b1, 5'd21, 32'h2);
    step(1'b1, 5'd9,  32'h92, 1'b1, 5'd22, 32'h3);
    idle(); chk("t5_p9_a", 64'(bus.pending[9]), 64'd1);
    idle(); chk("t5_p9_b", 64'(bus.pending[9]), 64'd1);
    idle(); chk("t5_p9_c", 64'(bus.pending[9]), 64'd1);
    chk("t5_wd_last9", 64'(bus.rf_wd), 64'h92);
    idle(); chk("t5_p9_d", 64'(bus.pending[9]), 64'd0);

    // Fill to DRAIN, retire one entry, then reset mid-drain.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'(12 + i), 32'(300 + i), 1'b1, 5'(25 + i), 32'(400 + i));
    idle();
    do_reset();
    idle();
    chk("t5_post_rst_we", 64'(bus.rf_we), 64'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 75, 5'($urandom_range(0, 12)), $urandom,
             $urandom_range(0, 99) < 45, 5'($urandom_range(0, 12)), $urandom);
      end
    end
    repeat (6) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
